v_counters_up_mod: RTL and testbench



---
 rtl/v_counters_up_mod.sv | 63 ++++++
 tb/tb_v_counters_up_mod.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_counters_up_mod.sv
// Programmable-terminal up counter: counts 0..max then wraps to 0, with load, enable,
// a combinational terminal-count flag, a registered wrap pulse and a sticky overflow flag.
module v_counters_up_mod #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] max,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_wrap;

  // All-ones also wraps, covering a loaded start value above max.
  assign at_wrap = ce & ~load & ((q_q == max) | (&q_q));

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (load) begin
      q_d = din;
    end else if (ce) begin
      if (at_wrap) begin
        q_d    = '0;
        wrap_d = 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
    // A wrap on the same edge as a clear keeps the flag set.
    if (clr_ovf) ovf_d = 1'b0;
    if (at_wrap) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Q    = q_q;
  assign tc   = (q_q == max);
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_v_counters_up_mod.sv
// Self-checking bench for v_counters_up_mod: directed scenarios plus randomized traffic
// against an integer reference model, and an 8-bit instance for the full-range wrap.
module tb_v_counters_up_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, load, clr_ovf;
  logic [3:0] din, max;
  logic [3:0] q;
  logic       tc, wrap, ovf;

  logic       rst8, ce8, load8, clr_ovf8;
  logic [7:0] din8, max8;
  logic [7:0] q8;
  logic       tc8, wrap8, ovf8;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers).
  int m_q, m_wrap, m_ovf;

  v_counters_up_mod #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .din(din), .max(max),
    .clr_ovf(clr_ovf), .Q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  v_counters_up_mod #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .ce(ce8), .load(load8), .din(din8), .max(max8),
    .clr_ovf(clr_ovf8), .Q(q8), .tc(tc8), .wrap(wrap8), .ovf(ovf8)
  );

  // Advance one edge, updating the model from the inputs sampled at that edge.
  task automatic tick();
    int nq, nw, no;
    if (rst) begin
      nq = 0; nw = 0; no = 0;
    end else begin
      no = clr_ovf ? 0 : m_ovf;
      nw = 0;
      if (load) nq = int'(din);
      else if (ce) begin
        nq = (m_q == int'(max)) ? 0 : (m_q + 1) % 16;
        nw = (nq == 0);
      end else nq = m_q;
      if (nw != 0) no = 1;
    end
    @(posedge clk);
    #1;
    m_q = nq; m_wrap = nw; m_ovf = no;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; load = 1'b0; clr_ovf = 1'b0; din = 4'd0; max = 4'd5;
    tick();
    n_tests++;
    if (q !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: Q=%0d wrap=%b ovf=%b tc=%b, want Q=0 wrap=0 ovf=0 tc=0",
               q, wrap, ovf, tc);
    end
    rst = 1'b0;
  endtask

  task automatic test_count_max5();
    int exp_q[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    max = 4'd5; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (q !== 4'(exp_q[i]) || tc !== (exp_q[i] == 5) || wrap !== (i == 5) ||
          ovf !== (i >= 5)) begin
        n_fail++;
        $display("FAIL count_max5[%0d]: Q=%0d tc=%b wrap=%b ovf=%b, want Q=%0d tc=%b wrap=%b ovf=%b",
                 i, q, tc, wrap, ovf, exp_q[i], exp_q[i] == 5, i == 5, i >= 5);
      end
    end
  endtask

  task automatic test_load_above_max();
    load = 1'b1; din = 4'd3; clr_ovf = 1'b1; ce = 1'b0; max = 4'd5;
    tick();
    clr_ovf = 1'b0; din = 4'd9; ce = 1'b1;
    tick();
    n_tests++;
    if (q !== 4'd9 || wrap !== 1'b0 || ovf !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load9: Q=%0d wrap=%b ovf=%b tc=%b, want Q=9 wrap=0 ovf=0 tc=0",
               q, wrap, ovf, tc);
    end
    load = 1'b0;
    for (int i = 10; i <= 16; i++) begin
      tick();
      n_tests++;
      if (q !== 4'(i % 16) || tc !== 1'b0 || wrap !== (i == 16) || ovf !== (i == 16)) begin
        n_fail++;
        $display("FAIL roll_above_max[%0d]: Q=%0d tc=%b wrap=%b ovf=%b, want Q=%0d tc=0 wrap=%b ovf=%b",
                 i, q, tc, wrap, ovf, i % 16, i == 16, i == 16);
      end
    end
  endtask

  task automatic test_max_zero();
    max = 4'd0; ce = 1'b1;
    #1;
    n_tests++;
    if (tc !== 1'b1) begin
      n_fail++;
      $display("FAIL max0_tc_pre: tc=%b, want 1", tc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (q !== 4'd0 || tc !== 1'b1 || wrap !== 1'b1 || ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL max0[%0d]: Q=%0d tc=%b wrap=%b ovf=%b, want Q=0 tc=1 wrap=1 ovf=1",
                 i, q, tc, wrap, ovf);
      end
    end
  endtask

  task automatic test_ovf_set_wins();
    load = 1'b1; din = 4'd7; max = 4'd7; ce = 1'b0; clr_ovf = 1'b1;
    tick();
    n_tests++;
    if (q !== 4'd7 || tc !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_setup: Q=%0d tc=%b ovf=%b, want Q=7 tc=1 ovf=0", q, tc, ovf);
    end
    load = 1'b0; ce = 1'b1; clr_ovf = 1'b1;
    tick();
    n_tests++;
    if (q !== 4'd0 || wrap !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: Q=%0d wrap=%b ovf=%b, want Q=0 wrap=1 ovf=1", q, wrap, ovf);
    end
    ce = 1'b0;
    tick();
    n_tests++;
    if (ovf !== 1'b0 || wrap !== 1'b0 || q !== 4'd0) begin
      n_fail++;
      $display("FAIL ovf_clear: Q=%0d wrap=%b ovf=%b, want Q=0 wrap=0 ovf=0", q, wrap, ovf);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_midcount();
    load = 1'b1; din = 4'd3; max = 4'd3; ce = 1'b0;
    tick();
    load = 1'b0; ce = 1'b1;
    tick();
    load = 1'b1; din = 4'd6; ce = 1'b0;
    tick();
    n_tests++;
    if (q !== 4'd6 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL midcount_setup: Q=%0d ovf=%b, want Q=6 ovf=1", q, ovf);
    end
    rst = 1'b1; ce = 1'b1; load = 1'b1; din = 4'd2;
    tick();
    n_tests++;
    if (q !== 4'd0 || wrap !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midcount: Q=%0d wrap=%b ovf=%b, want Q=0 wrap=0 ovf=0", q, wrap, ovf);
    end
    rst = 1'b0; load = 1'b0; ce = 1'b0;
    tick();
    n_tests++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_after_reset: Q=%0d wrap=%b, want Q=0 wrap=0", q, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 31) == 0);
      load    = ($urandom_range(0, 7) == 0);
      ce      = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 7) == 0);
      din     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) max = 4'($urandom_range(0, 15));
      tick();
      n_tests++;
      if (q !== 4'(m_q) || wrap !== (m_wrap != 0) || ovf !== (m_ovf != 0) ||
          tc !== (m_q == int'(max))) begin
        n_fail++;
        $display("FAIL random[%0d]: Q=%0d tc=%b wrap=%b ovf=%b, want Q=%0d tc=%b wrap=%0d ovf=%0d",
                 i, q, tc, wrap, ovf, m_q, m_q == int'(max), m_wrap, m_ovf);
      end
    end
    rst = 1'b0; load = 1'b0; ce = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_width8();
    int n_wraps, wrap_at;
    n_wraps = 0; wrap_at = -1;
    rst8 = 1'b1; ce8 = 1'b1; max8 = 8'd255;
    @(posedge clk); #1;
    rst8 = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      @(posedge clk); #1;
      if (wrap8) begin
        n_wraps++;
        wrap_at = i;
        n_tests++;
        if (q8 !== 8'd0) begin
          n_fail++;
          $display("FAIL w8_wrap_q: Q=%0d, want 0", q8);
        end
      end
    end
    n_tests++;
    if (n_wraps != 1 || wrap_at != 256) begin
      n_fail++;
      $display("FAIL w8_single_wrap: wraps=%0d at edge %0d, want 1 at edge 256", n_wraps, wrap_at);
    end
    n_tests++;
    if (q8 !== 8'd1 || ovf8 !== 1'b1 || tc8 !== 1'b0) begin
      n_fail++;
      $display("FAIL w8_final: Q=%0d ovf=%b tc=%b, want Q=1 ovf=1 tc=0", q8, ovf8, tc8);
    end
    ce8 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b1; ce8 = 1'b0; load8 = 1'b0; clr_ovf8 = 1'b0; din8 = 8'd0; max8 = 8'd0;
    m_q = 0; m_wrap = 0; m_ovf = 0;
    test_reset();
    test_count_max5();
    test_load_above_max();
    test_max_zero();
    test_ovf_set_wins();
    test_reset_midcount();
    test_random();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
